// File: rtl/mem_ram4x64_arb_if.sv
// mem_ram4x64_arb_if: client request/response, hold and RAM command bundle for the arbiter
interface mem_ram4x64_arb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2
);
  logic hold;
  logic req0_valid, req0_ready, req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic req1_valid, req1_ready, req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic mem_wr_en, mem_rd_en;
  logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
  logic [DATA_W-1:0] mem_wr_data, mem_rd_data;
  logic [2:0] rd_pending;
  modport slave (
    input  hold, req0_valid, req0_we, req0_addr, req0_wdata,
           req1_valid, req1_we, req1_addr, req1_wdata, mem_rd_data,
    output req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, rd_pending
  );
  modport master (
    output hold, req0_valid, req0_we, req0_addr, req0_wdata,
           req1_valid, req1_we, req1_addr, req1_wdata, mem_rd_data,
    input  req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
           mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr, rd_pending
  );
endinterface

// File: rtl/mem_ram4x64_arb.sv
// mem_ram4x64_arb: two-client arbiter/sequencer for the 4x64 RAM with tagged in-order read return
module mem_ram4x64_arb #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  mem_ram4x64_arb_if.slave io_bus
);
  logic w_ok, w_conf, w_rdy0, w_rdy1, w_wr0, w_wr1, w_rd0, w_rd1, w_rsp_v, w_rsp_id;
  logic r_last, r_wr_en, r_rd_en, r_rd_id;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [RD_LAT-1:0] r_tag_v, r_tag_id;
  logic [2:0] r_pend;
  always_comb begin
    w_ok = rst_n && !io_bus.hold;
    w_conf = io_bus.req0_valid && io_bus.req1_valid && (io_bus.req0_we == io_bus.req1_we);
    w_rdy0 = w_ok && io_bus.req0_valid && (!w_conf || r_last);
    w_rdy1 = w_ok && io_bus.req1_valid && (!w_conf || !r_last);
    w_wr0 = w_rdy0 && io_bus.req0_we;
    w_wr1 = w_rdy1 && io_bus.req1_we;
    w_rd0 = w_rdy0 && !io_bus.req0_we;
    w_rd1 = w_rdy1 && !io_bus.req1_we;
    w_rsp_v = r_tag_v[RD_LAT-1];
    w_rsp_id = r_tag_id[RD_LAT-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_id <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_wr_data <= '0;
      r_tag_v <= '0;
      r_tag_id <= '0;
      r_pend <= '0;
    end else begin
      if (w_ok && w_conf) r_last <= !r_last;
      r_wr_en <= w_wr0 || w_wr1;
      if (w_wr0 || w_wr1) begin
        r_wr_addr <= w_wr0 ? io_bus.req0_addr : io_bus.req1_addr;
        r_wr_data <= w_wr0 ? io_bus.req0_wdata : io_bus.req1_wdata;
      end
      r_rd_en <= w_rd0 || w_rd1;
      if (w_rd0 || w_rd1) begin
        r_rd_addr <= w_rd0 ? io_bus.req0_addr : io_bus.req1_addr;
        r_rd_id <= w_rd1;
      end
      r_tag_v <= (r_tag_v << 1) | RD_LAT'(r_rd_en);
      r_tag_id <= (r_tag_id << 1) | RD_LAT'(r_rd_en && r_rd_id);
      r_pend <= r_pend + {2'b0, r_rd_en} - {2'b0, w_rsp_v};
    end
  end
  assign io_bus.req0_ready = w_rdy0;
  assign io_bus.req1_ready = w_rdy1;
  assign io_bus.mem_wr_en = r_wr_en;
  assign io_bus.mem_wr_addr = r_wr_addr;
  assign io_bus.mem_wr_data = r_wr_data;
  assign io_bus.mem_rd_en = r_rd_en;
  assign io_bus.mem_rd_addr = r_rd_addr;
  assign io_bus.rsp0_valid = w_rsp_v && !w_rsp_id;
  assign io_bus.rsp1_valid = w_rsp_v && w_rsp_id;
  assign io_bus.rsp0_data = io_bus.mem_rd_data;
  assign io_bus.rsp1_data = io_bus.mem_rd_data;
  assign io_bus.rd_pending = r_pend;
endmodule

// File: doc/mem_ram4x64_arb.md
Name: mem_ram4x64_arb

Overview:
- Two-requester arbiter/sequencer in front of the 4x64 vendor RAM: one write port, one read port, 2-clock read latency.
- Accepts valid/ready requests from two clients and issues registered commands to the RAM.
- Tracks in-flight reads with a tag pipeline and returns read data to the originating client.
- Sits between the router's queue logic and the vendor memory macro; the BIST ports are not touched.

Parameters:
- DATA_W, 64, data width; must match the RAM.
- ADDR_W, 2, address width.
- RD_LAT, 2, RAM cycles from mem_rd_en to valid mem_rd_data; supported range 1..4.

Ports:
- clk  in  1  clock for the block and the RAM.
- rst_n  in  1  synchronous active-low reset.
- hold  in  1  when 1, no new requests are granted; in-flight reads still complete.
- req0_valid  in  1  client 0 request.
- req0_ready  out  1  client 0 grant; combinational from valid/hold/arbitration state.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  address.
- req0_wdata  in  DATA_W  write data.
- rsp0_valid  out  1  read data valid for client 0.
- rsp0_data  out  DATA_W  read data.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_data: same as client 0.
- mem_wr_en  out  1  to RAM.
- mem_wr_addr  out  ADDR_W  to RAM.
- mem_wr_data  out  DATA_W  to RAM.
- mem_rd_en  out  1  to RAM.
- mem_rd_addr  out  ADDR_W  to RAM.
- mem_rd_data  in  DATA_W  from RAM.
- rd_pending  out  3  count of issued reads with no response yet.

Behaviour:
- Accept: a transfer occurs in cycle A when reqN_valid && reqN_ready. The command is registered and drives the mem_* outputs in cycle A+1 (issue cycle C).
- Grant rules, with hold=0:
  - Only one client valid: that client is granted.
  - Both valid with different req_we: both are granted in the same cycle. The write goes to the write port and the read to the read port.
  - Both valid with the same req_we: round-robin. The client not granted last conflict wins. The last_conflict_winner register updates only on same-type conflicts and resets to 1, so client 0 wins the first conflict.
- hold=1: both ready outputs are 0. Issue cycles already scheduled still complete.
- Mem outputs are registered:
  - mem_wr_en and mem_rd_en are 0 in any cycle with no issued command.
  - mem_*_addr and mem_wr_data hold their last value when the enable is 0; their reset value is 0.
- Read return: the issue cycle C pushes tag {valid, id} into an RD_LAT-deep shift register.
  - In cycle C+RD_LAT, rspN_valid=1 for the tagged id.
  - rspN_data = mem_rd_data (combinational passthrough).
  - Total accept-to-response latency is RD_LAT+1 cycles (3 by default).
  - rspN_data is don't-care when rspN_valid=0.
- Throughput: one read and one write per cycle sustained, with no bubbles. Responses are in order; responses never overlap because at most one read issues per cycle.
- Hazards:
  - Write and read to the same address in the same issue cycle: the read returns the OLD data (RAM read-before-write).
  - Read issued in any cycle after the write's issue cycle: returns the new data.
  - The block does no forwarding.
- rd_pending: +1 on each read issue, -1 on each response; both in the same cycle leaves it unchanged. Maximum value is RD_LAT.
- Reset (rst_n=0 at a clock edge):
  - All outputs go to 0 and the tag pipeline clears.
  - last_conflict_winner = 1, rd_pending = 0.
  - Reads in flight at reset produce no response after reset.
  - req_ready is 0 while rst_n=0.

Test Plan:
- Single write then read: client 0 writes addr 2 = 0xDEADBEEF_00000001 in cycle 0, reads addr 2 in cycle 1 -> mem_wr_en=1 in cycle 1; mem_rd_en=1 in cycle 2; rsp0_valid=1 with that data in cycle 4, rsp1_valid stays 0.
- Same-type conflict: both clients read every cycle for 4 cycles (c0 addr 0, c1 addr 1, preloaded 0x..A0 / 0x..B1) -> grants alternate c0, c1, c0, c1; responses alternate rsp0/rsp1 starting 3 cycles after the first accept; rd_pending peaks at 2.
- Mixed-type parallel: c0 writes addr 3 = 0x55, c1 reads addr 3 (old 0xAA) in the same cycle -> both ready=1; rsp1_data=0xAA. A c1 re-read of addr 3 the next cycle -> 0x55.
- Hold: hold=1 for 3 cycles with both valid and one read in flight -> no ready, no new mem enables; the in-flight response still arrives on schedule; grants resume the cycle hold drops.
- Reset mid-read: read accepted in cycle A, rst_n=0 at the edge ending cycle A+1 -> no rspN_valid ever pulses; rd_pending=0; first conflict after reset is won by client 0.
- RD_LAT=1 build: single read -> response 2 cycles after accept; back-to-back reads at full rate are all returned.
